// File: rtl/cae_pers_pkg.sv
// Shared constants for the PDES personality control core:
// AEG indices, FSM state encoding, exception bits, CSR addresses.
package cae_pers_pkg;

   localparam int AEG_MASK = 0;
   localparam int AEG_TMO  = 1;
   localparam int AEG_GVT  = 2;
   localparam int AEG_STAT = 3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_RUN  = 3'd2,
      S_FIN  = 3'd3
   } state_t;

   localparam int EX_INST = 0;
   localparam int EX_IDX  = 1;
   localparam int EX_BUSY = 2;
   localparam int EX_MASK = 3;
   localparam int EX_TMO  = 4;

   localparam logic [15:0] CSR_STAT = 16'h0;
   localparam logic [15:0] CSR_GVT  = 16'h1;
   localparam logic [15:0] CSR_CYC  = 16'h2;
   localparam logic [15:0] CSR_DONE = 16'h3;

   localparam logic [4:0] INST_START = 5'd0;

endpackage

// File: rtl/gvt_min_reduce.sv
// Registered minimum over N masked W-bit results (1-cycle latency).
// Ports: i_vld/i_mask/i_res in, o_vld/o_min out (o_min=0 if mask empty).
module gvt_min_reduce #(
   parameter int N = 4,
   parameter int W = 14
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_vld,
   input  logic [N-1:0]   i_mask,
   input  logic [N*W-1:0] i_res,
   output logic           o_vld,
   output logic [W-1:0]   o_min
);

   logic [W-1:0] w_min;
   logic         w_any;
   logic         r_vld;
   logic [W-1:0] r_min;

   always_comb begin
      w_min = '0;
      w_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i_mask[i] && (!w_any || i_res[i*W +: W] < w_min)) begin
            w_min = i_res[i*W +: W];
            w_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld <= 1'b0;
         r_min <= '0;
      end else begin
         r_vld <= i_vld;
         if (i_vld) r_min <= w_min;
      end
   end

   assign o_vld = r_vld;
   assign o_min = r_min;

endmodule

// File: rtl/cae_pers_ctl.sv
// Dispatch/control core: AEG file, start FSM, engine run/wait, GVT min.
// Ports: disp_* dispatch, eng_* engine control/results, csr_* CSR reads.
module cae_pers_ctl
   import cae_pers_pkg::*;
#(
   parameter int NUM_ENG = 4,
   parameter int NA      = 4,
   parameter int RES_W   = 14,
   parameter int CYC_W   = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     disp_inst_vld,
   input  logic [4:0]               disp_inst,
   input  logic [17:0]              disp_aeg_idx,
   input  logic                     disp_aeg_rd,
   input  logic                     disp_aeg_wr,
   input  logic [63:0]              disp_aeg_wr_data,
   output logic [17:0]              disp_aeg_cnt,
   output logic [15:0]              disp_exception,
   output logic                     disp_idle,
   output logic                     disp_stall,
   output logic                     disp_rtn_data_vld,
   output logic [63:0]              disp_rtn_data,
   output logic [NUM_ENG-1:0]       eng_rst_n,
   input  logic [NUM_ENG-1:0]       eng_done,
   input  logic [NUM_ENG*RES_W-1:0] eng_result,
   input  logic                     csr_rd_vld,
   input  logic [15:0]              csr_address,
   output logic                     csr_rd_ack,
   output logic [63:0]              csr_rd_data
);

   localparam int NB = (NA > 1) ? $clog2(NA) : 1;

   state_t                   r_state, w_nxt;
   logic                     r_start;
   logic [NUM_ENG-1:0]       r_mask, r_done, w_done_nxt;
   logic [63:0]              r_tmo;
   logic [RES_W-1:0]         r_gvt, w_red_min;
   logic [NUM_ENG*RES_W-1:0] r_res, w_res_nxt;
   logic [CYC_W-1:0]         r_cyc;
   logic                     r_to;
   logic [15:0]              r_exc;
   logic                     r_rtn_vld, r_csr_ack;
   logic [63:0]              r_rtn_data, r_csr_data;
   logic [63:0]              w_status, w_rd_data, w_csr_data;
   logic [NB-1:0]            w_idx;
   logic                     w_idx_ok, w_idx_rw, w_start_req;
   logic                     w_cmp, w_to_hit, w_exit, w_red_vld;

   assign w_start_req = disp_inst_vld && (disp_inst == INST_START);
   assign w_idx_ok    = disp_aeg_idx < 18'(NA);
   assign w_idx       = disp_aeg_idx[NB-1:0];
   assign w_idx_rw    = w_idx_ok && (w_idx == NB'(AEG_MASK) ||
                                     w_idx == NB'(AEG_TMO));

   // first done of each enabled engine latches its result
   assign w_done_nxt = r_done | (eng_done & r_mask);
   always_comb begin
      w_res_nxt = r_res;
      for (int i = 0; i < NUM_ENG; i++) begin
         if (eng_done[i] && r_mask[i] && !r_done[i])
            w_res_nxt[i*RES_W +: RES_W] = eng_result[i*RES_W +: RES_W];
      end
   end

   // timeout counted in RUN cycles; completion on the same cycle wins
   assign w_cmp    = (w_done_nxt == r_mask);
   assign w_to_hit = (r_tmo != 64'd0) && (64'(r_cyc) == r_tmo - 64'd1);
   assign w_exit   = (r_state == S_RUN) && (w_cmp || w_to_hit);

   gvt_min_reduce #(.N(NUM_ENG), .W(RES_W)) u_red (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_vld  (w_exit),
      .i_mask (w_done_nxt),
      .i_res  (w_res_nxt),
      .o_vld  (w_red_vld),
      .o_min  (w_red_min)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (r_start) w_nxt = S_ARM;
         S_ARM:   w_nxt = (r_mask == '0) ? S_IDLE : S_RUN;
         S_RUN:   if (w_exit) w_nxt = S_FIN;
         S_FIN:   if (w_red_vld) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      eng_rst_n  = '0;
      disp_idle  = 1'b0;
      disp_stall = 1'b1;
      if (r_state == S_RUN) eng_rst_n = r_mask;
      if (r_state == S_IDLE) begin
         disp_idle  = !r_start;
         disp_stall = r_start || w_start_req;
      end
   end

   assign w_status = 64'({r_done, r_to, r_state});

   always_comb begin
      w_rd_data = '0;
      if (w_idx_ok) begin
         case (w_idx)
            NB'(AEG_MASK): w_rd_data = 64'(r_mask);
            NB'(AEG_TMO):  w_rd_data = r_tmo;
            NB'(AEG_GVT):  w_rd_data = 64'(r_gvt);
            NB'(AEG_STAT): w_rd_data = w_status;
            default:       w_rd_data = '0;
         endcase
      end
   end

   always_comb begin
      case (csr_address)
         CSR_STAT: w_csr_data = w_status;
         CSR_GVT:  w_csr_data = 64'(r_gvt);
         CSR_CYC:  w_csr_data = 64'(r_cyc);
         CSR_DONE: w_csr_data = 64'(r_done);
         default:  w_csr_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_start    <= 1'b0;
         r_mask     <= '0;
         r_tmo      <= '0;
         r_gvt      <= '0;
         r_res      <= '0;
         r_done     <= '0;
         r_cyc      <= '0;
         r_to       <= 1'b0;
         r_exc      <= '0;
         r_rtn_vld  <= 1'b0;
         r_rtn_data <= '0;
         r_csr_ack  <= 1'b0;
         r_csr_data <= '0;
      end else begin
         r_exc      <= '0;
         r_start    <= w_start_req && (r_state == S_IDLE) && !r_start;
         r_rtn_vld  <= disp_aeg_rd;
         r_rtn_data <= disp_aeg_rd ? w_rd_data : '0;
         r_csr_ack  <= csr_rd_vld;
         r_csr_data <= csr_rd_vld ? w_csr_data : '0;
         if (disp_inst_vld && disp_inst != INST_START)
            r_exc[EX_INST] <= 1'b1;
         if (disp_aeg_rd && !w_idx_ok)
            r_exc[EX_IDX] <= 1'b1;
         if (disp_aeg_wr && w_idx_rw) begin
            if (r_state != S_IDLE) begin
               r_exc[EX_BUSY] <= 1'b1;
            end else if (w_idx == NB'(AEG_MASK)) begin
               r_mask <= disp_aeg_wr_data[NUM_ENG-1:0];
            end else begin
               r_tmo <= disp_aeg_wr_data;
            end
         end
         if (r_state == S_ARM) begin
            r_cyc  <= '0;
            r_done <= '0;
            r_to   <= 1'b0;
            if (r_mask == '0) r_exc[EX_MASK] <= 1'b1;
         end
         if (r_state == S_RUN) begin
            r_done <= w_done_nxt;
            r_res  <= w_res_nxt;
            if (r_cyc != '1) r_cyc <= r_cyc + CYC_W'(1);
            if (!w_cmp && w_to_hit) begin
               r_to           <= 1'b1;
               r_exc[EX_TMO]  <= 1'b1;
            end
         end
         if (r_state == S_FIN && w_red_vld)
            r_gvt <= w_red_min;
      end
   end

   assign disp_aeg_cnt      = 18'(NA);
   assign disp_exception    = r_exc;
   assign disp_rtn_data_vld = r_rtn_vld;
   assign disp_rtn_data     = r_rtn_data;
   assign csr_rd_ack        = r_csr_ack;
   assign csr_rd_data       = r_csr_data;

endmodule

// File: tb/tb_cae_pers_ctl.sv
// Self-checking bench for cae_pers_ctl: AEG access, runs, timeout,
// exceptions and mid-run reset, with read/CSR scoreboards.
module tb_cae_pers_ctl;

   localparam int NUM_ENG = 4;
   localparam int RES_W   = 14;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     disp_inst_vld = 1'b0;
   logic [4:0]               disp_inst = '0;
   logic [17:0]              disp_aeg_idx = '0;
   logic                     disp_aeg_rd = 1'b0;
   logic                     disp_aeg_wr = 1'b0;
   logic [63:0]              disp_aeg_wr_data = '0;
   logic [17:0]              disp_aeg_cnt;
   logic [15:0]              disp_exception;
   logic                     disp_idle;
   logic                     disp_stall;
   logic                     disp_rtn_data_vld;
   logic [63:0]              disp_rtn_data;
   logic [NUM_ENG-1:0]       eng_rst_n;
   logic [NUM_ENG-1:0]       eng_done = '0;
   logic [NUM_ENG*RES_W-1:0] eng_result = '0;
   logic                     csr_rd_vld = 1'b0;
   logic [15:0]              csr_address = '0;
   logic                     csr_rd_ack;
   logic [63:0]              csr_rd_data;

   always #5 clk = ~clk;

   cae_pers_ctl #(.NUM_ENG(4), .NA(4), .RES_W(14), .CYC_W(32)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .disp_inst_vld     (disp_inst_vld),
      .disp_inst         (disp_inst),
      .disp_aeg_idx      (disp_aeg_idx),
      .disp_aeg_rd       (disp_aeg_rd),
      .disp_aeg_wr       (disp_aeg_wr),
      .disp_aeg_wr_data  (disp_aeg_wr_data),
      .disp_aeg_cnt      (disp_aeg_cnt),
      .disp_exception    (disp_exception),
      .disp_idle         (disp_idle),
      .disp_stall        (disp_stall),
      .disp_rtn_data_vld (disp_rtn_data_vld),
      .disp_rtn_data     (disp_rtn_data),
      .eng_rst_n         (eng_rst_n),
      .eng_done          (eng_done),
      .eng_result        (eng_result),
      .csr_rd_vld        (csr_rd_vld),
      .csr_address       (csr_address),
      .csr_rd_ack        (csr_rd_ack),
      .csr_rd_data       (csr_rd_data)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          exc_cnt [16];
   logic [63:0] q_rd [$];
   logic [63:0] q_csr [$];

   always @(negedge clk)
      for (int b = 0; b < 16; b++)
         if (disp_exception[b]) exc_cnt[b]++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic aeg_wr(input logic [17:0] idx, input logic [63:0] d);
      disp_aeg_idx     = idx;
      disp_aeg_wr_data = d;
      disp_aeg_wr      = 1'b1;
      tick();
      disp_aeg_wr      = 1'b0;
   endtask

   task automatic aeg_rd(input logic [17:0] idx, input logic [63:0] exp,
                         input string nm);
      logic [63:0] e;
      q_rd.push_back(exp);
      disp_aeg_idx = idx;
      disp_aeg_rd  = 1'b1;
      tick();
      disp_aeg_rd  = 1'b0;
      n_tests++;
      e = q_rd.pop_front();
      if (disp_rtn_data_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: rtn_vld=%b required 1", nm, disp_rtn_data_vld);
      end else if (disp_rtn_data !== e) begin
         n_fail++;
         $display("FAIL %s: data=0x%0h required 0x%0h", nm, disp_rtn_data, e);
      end
   endtask

   task automatic csr_rd(input logic [15:0] a, input logic [63:0] exp,
                         input string nm);
      logic [63:0] e;
      q_csr.push_back(exp);
      csr_address = a;
      csr_rd_vld  = 1'b1;
      tick();
      csr_rd_vld  = 1'b0;
      n_tests++;
      e = q_csr.pop_front();
      if (csr_rd_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: csr_ack=%b required 1", nm, csr_rd_ack);
      end else if (csr_rd_data !== e) begin
         n_fail++;
         $display("FAIL %s: csr=0x%0h required 0x%0h", nm, csr_rd_data, e);
      end
   endtask

   task automatic issue(input logic [4:0] code);
      disp_inst     = code;
      disp_inst_vld = 1'b1;
      tick();
      disp_inst_vld = 1'b0;
   endtask

   task automatic eng_pulse(input logic [3:0] d, input int r0, input int r1,
                            input int r2, input int r3);
      eng_done   = d;
      eng_result = {RES_W'(r3), RES_W'(r2), RES_W'(r1), RES_W'(r0)};
      tick();
      eng_done   = '0;
   endtask

   task automatic wait_run(input string nm);
      for (int i = 0; i < 10; i++) begin
         if (eng_rst_n != '0) break;
         tick();
      end
      n_tests++;
      if (eng_rst_n == '0) begin
         n_fail++;
         $display("FAIL %s: eng_rst_n=0x%0h never raised", nm, eng_rst_n);
      end
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 400; i++) begin
         if (disp_idle === 1'b1) break;
         tick();
      end
      n_tests++;
      if (disp_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: idle=%b required 1 (cycle budget)", nm, disp_idle);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      n_tests++;
      if ({disp_aeg_cnt, disp_idle, disp_stall, eng_rst_n, disp_exception,
           disp_rtn_data_vld, csr_rd_ack} !== {18'd4, 1'b1, 1'b0, 4'h0,
           16'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_out: cnt=%0d idle=%b stall=%b eng=%h exc=%h required 4 1 0 0 0",
                  disp_aeg_cnt, disp_idle, disp_stall, eng_rst_n, disp_exception);
      end
      for (int i = 0; i < 4; i++) aeg_rd(18'(i), 64'd0, "reset_aeg");
      csr_rd(16'h0, 64'd0, "reset_csr_stat");
   endtask

   task automatic test_full_mask();
      int e4;
      e4 = exc_cnt[4];
      aeg_wr(18'd0, 64'hF);
      aeg_wr(18'd1, 64'd0);
      issue(5'd0);
      wait_run("full_run");
      n_tests++;
      if ({eng_rst_n, disp_stall, disp_idle} !== {4'hF, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL full_busy: eng=%h stall=%b idle=%b required f 1 0",
                  eng_rst_n, disp_stall, disp_idle);
      end
      eng_pulse(4'b0001, 30, 0, 0, 0);
      eng_pulse(4'b0001, 5, 0, 0, 0);
      eng_pulse(4'b0010, 0, 12, 0, 0);
      eng_pulse(4'b1100, 0, 0, 55, 40);
      wait_idle("full_idle");
      aeg_rd(18'd2, 64'd12, "full_gvt");
      aeg_rd(18'd3, 64'hF0, "full_status");
      aeg_rd(18'd0, 64'hF, "full_mask");
      csr_rd(16'h1, 64'd12, "full_csr_gvt");
      csr_rd(16'h3, 64'hF, "full_csr_done");
      csr_rd(16'h7, 64'd0, "full_csr_other");
      n_tests++;
      if (exc_cnt[4] != e4) begin
         n_fail++;
         $display("FAIL full_no_tmo: exc4 count=%0d required %0d", exc_cnt[4], e4);
      end
   endtask

   task automatic test_partial_mask();
      int e1, e2;
      aeg_wr(18'd0, 64'h5);
      issue(5'd0);
      wait_run("part_run");
      n_tests++;
      if (eng_rst_n !== 4'h5) begin
         n_fail++;
         $display("FAIL part_eng_rst: eng=%h required 5", eng_rst_n);
      end
      e1 = exc_cnt[1];
      e2 = exc_cnt[2];
      aeg_wr(18'd0, 64'hA);
      aeg_rd(18'd5, 64'd0, "part_bad_idx");
      aeg_rd(18'd0, 64'h5, "part_mask_kept");
      eng_pulse(4'b0011, 9, 1, 0, 0);
      eng_pulse(4'b0100, 0, 0, 7, 0);
      wait_idle("part_idle");
      aeg_rd(18'd2, 64'd7, "part_gvt");
      aeg_rd(18'd3, 64'h50, "part_status");
      n_tests++;
      if (exc_cnt[2] - e2 != 1 || exc_cnt[1] - e1 != 1) begin
         n_fail++;
         $display("FAIL part_exc: exc2 delta=%0d exc1 delta=%0d required 1 1",
                  exc_cnt[2] - e2, exc_cnt[1] - e1);
      end
   endtask

   task automatic test_timeout();
      int e4, n_run;
      e4 = exc_cnt[4];
      aeg_wr(18'd0, 64'hF);
      aeg_wr(18'd1, 64'd100);
      issue(5'd0);
      wait_run("tmo_run");
      n_run = 1;
      eng_pulse(4'b0111, 20, 15, 33, 0);
      for (int i = 0; i < 300; i++) begin
         if (eng_rst_n == '0) break;
         n_run++;
         tick();
      end
      n_tests++;
      if (n_run != 100) begin
         n_fail++;
         $display("FAIL tmo_len: run cycles=%0d required 100", n_run);
      end
      wait_idle("tmo_idle");
      tick();
      aeg_rd(18'd2, 64'd15, "tmo_gvt");
      aeg_rd(18'd3, 64'h78, "tmo_status");
      csr_rd(16'h2, 64'd100, "tmo_csr_cyc");
      n_tests++;
      if (exc_cnt[4] - e4 != 1) begin
         n_fail++;
         $display("FAIL tmo_exc: exc4 delta=%0d required 1", exc_cnt[4] - e4);
      end
   endtask

   task automatic test_done_at_timeout();
      int e4;
      e4 = exc_cnt[4];
      aeg_wr(18'd0, 64'h1);
      aeg_wr(18'd1, 64'd10);
      issue(5'd0);
      wait_run("edge_run");
      repeat (9) tick();
      n_tests++;
      if (eng_rst_n !== 4'h1) begin
         n_fail++;
         $display("FAIL edge_still_run: eng=%h required 1", eng_rst_n);
      end
      eng_pulse(4'b0001, 77, 0, 0, 0);
      wait_idle("edge_idle");
      tick();
      aeg_rd(18'd2, 64'd77, "edge_gvt");
      aeg_rd(18'd3, 64'h10, "edge_status");
      n_tests++;
      if (exc_cnt[4] != e4) begin
         n_fail++;
         $display("FAIL edge_exc: exc4 delta=%0d required 0", exc_cnt[4] - e4);
      end
   endtask

   task automatic test_inst_errors();
      int e0, e3, bad;
      e0 = exc_cnt[0];
      e3 = exc_cnt[3];
      bad = 0;
      issue(5'd3);
      for (int i = 0; i < 4; i++) begin
         if (disp_idle !== 1'b1 || eng_rst_n !== 4'h0) bad++;
         tick();
      end
      n_tests++;
      if (bad != 0 || exc_cnt[0] - e0 != 1) begin
         n_fail++;
         $display("FAIL inst_bad: idle errs=%0d exc0 delta=%0d required 0 1",
                  bad, exc_cnt[0] - e0);
      end
      aeg_wr(18'd0, 64'd0);
      disp_inst     = 5'd0;
      disp_inst_vld = 1'b1;
      #1;
      n_tests++;
      if (disp_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL inst_stall: stall=%b required 1", disp_stall);
      end
      tick();
      disp_inst_vld = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (eng_rst_n !== 4'h0) bad++;
         tick();
      end
      wait_idle("inst_mask0_idle");
      n_tests++;
      if (bad != 0 || exc_cnt[3] - e3 != 1) begin
         n_fail++;
         $display("FAIL inst_mask0: eng errs=%0d exc3 delta=%0d required 0 1",
                  bad, exc_cnt[3] - e3);
      end
   endtask

   task automatic test_back_to_back();
      logic [17:0] idx [5];
      logic [63:0] exp [5];
      logic [63:0] e;
      int e1, e2;
      e1 = exc_cnt[1];
      e2 = exc_cnt[2];
      aeg_wr(18'd0, 64'h3);
      aeg_wr(18'd1, 64'h1234_5678_9ABC_DEF0);
      aeg_wr(18'd2, 64'd99);
      idx = '{18'd0, 18'd1, 18'd4, 18'd2, 18'd3};
      exp = '{64'h3, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd77, 64'd0};
      for (int i = 0; i < 5; i++) begin
         q_rd.push_back(exp[i]);
         disp_aeg_idx = idx[i];
         disp_aeg_rd  = 1'b1;
         tick();
         e = q_rd.pop_front();
         n_tests++;
         if (disp_rtn_data_vld !== 1'b1 || disp_rtn_data !== e) begin
            n_fail++;
            $display("FAIL b2b_rd%0d: vld=%b data=0x%0h required 1 0x%0h",
                     i, disp_rtn_data_vld, disp_rtn_data, e);
         end
      end
      disp_aeg_rd = 1'b0;
      tick();
      n_tests++;
      if (exc_cnt[1] - e1 != 1 || exc_cnt[2] != e2) begin
         n_fail++;
         $display("FAIL b2b_exc: exc1 delta=%0d exc2 delta=%0d required 1 0",
                  exc_cnt[1] - e1, exc_cnt[2] - e2);
      end
   endtask

   task automatic test_reset_mid_run();
      aeg_wr(18'd0, 64'hF);
      aeg_wr(18'd1, 64'd500);
      issue(5'd0);
      wait_run("rst_run");
      eng_pulse(4'b0001, 5, 0, 0, 0);
      rst_n = 1'b0;
      tick();
      n_tests++;
      if ({eng_rst_n, disp_idle, disp_stall} !== {4'h0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_mid: eng=%h idle=%b stall=%b required 0 1 0",
                  eng_rst_n, disp_idle, disp_stall);
      end
      rst_n = 1'b1;
      aeg_rd(18'd0, 64'd0, "rst_aeg0");
      aeg_rd(18'd1, 64'd0, "rst_aeg1");
      aeg_rd(18'd2, 64'd0, "rst_aeg2");
      aeg_rd(18'd3, 64'd0, "rst_aeg3");
      csr_rd(16'h0, 64'd0, "rst_csr_stat");
      csr_rd(16'h3, 64'd0, "rst_csr_done");
   endtask

   initial begin
      test_reset();
      test_full_mask();
      test_partial_mask();
      test_timeout();
      test_done_at_timeout();
      test_inst_errors();
      test_back_to_back();
      test_reset_mid_run();
      n_tests++;
      if (q_rd.size() != 0 || q_csr.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: rd left=%0d csr left=%0d required 0 0",
                  q_rd.size(), q_csr.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
